// File: rtl/bht_pkg.sv
// bht_pkg: shared state, counter type and saturating arithmetic for the BHT port scheduler
package bht_pkg;
    typedef enum logic [1:0] {INIT, RUN, UPD_RD, UPD_WR} state_e;
    typedef logic [1:0] cnt_t;
    localparam cnt_t CNT_WNT = 2'b01;
    function automatic cnt_t sat_update(cnt_t cnt, logic taken);
        return taken ? ((cnt == 2'b11) ? cnt : cnt + 2'b01)
                     : ((cnt == 2'b00) ? cnt : cnt - 2'b01);
    endfunction
endpackage

// File: rtl/bht_update_fifo.sv
// bht_update_fifo: small circular FIFO holding resolved branch updates until the port is free
module bht_update_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(do_push);
            rd_q  <= rd_q + PW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
    // storage needs no reset: only slots below the occupancy count are ever read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/bht_port_scheduler.sv
// bht_port_scheduler: arbitrates one single-ported 2-bit BHT between lookups and queued updates
module bht_port_scheduler
    import bht_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_ready,
    output logic              lk_resp_valid,
    output logic              lk_taken,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic              up_taken,
    output logic              up_ready,
    output logic              tbl_en,
    output logic              tbl_we,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic [1:0]        tbl_wdata,
    input  logic [1:0]        tbl_rdata,
    output logic              init_done
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, upd_addr_q, upd_addr_d;
    logic              upd_taken_q, upd_taken_d;
    logic              lk_resp_valid_q, lk_resp_valid_d;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [ADDR_W:0]   fifo_head;

    bht_update_fifo #(.WIDTH(ADDR_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (up_valid),
        .data_i  ({up_taken, up_addr}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign up_ready      = !fifo_full;
    assign init_done     = (state_q != INIT);
    assign lk_resp_valid = lk_resp_valid_q;
    assign lk_taken      = lk_resp_valid_q & tbl_rdata[1];

    // port arbitration: clear sweep, then lookups win unless the FIFO is full
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        upd_addr_d      = upd_addr_q;
        upd_taken_d     = upd_taken_q;
        lk_resp_valid_d = 1'b0;
        fifo_pop        = 1'b0;
        lk_ready        = 1'b0;
        tbl_en          = 1'b0;
        tbl_we          = 1'b0;
        tbl_addr        = upd_addr_q;
        tbl_wdata       = CNT_WNT;
        case (state_q)
            INIT: begin
                tbl_en   = 1'b1;
                tbl_we   = 1'b1;
                tbl_addr = idx_q;
                idx_d    = idx_q + 1'b1;
                state_d  = (idx_q == '1) ? RUN : INIT;
            end
            RUN: begin
                lk_ready = !fifo_full;
                if (lk_valid && !fifo_full) begin
                    tbl_en          = 1'b1;
                    tbl_addr        = lk_addr;
                    lk_resp_valid_d = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop                  = 1'b1;
                    {upd_taken_d, upd_addr_d} = fifo_head;
                    state_d                   = UPD_RD;
                end
            end
            UPD_RD: begin
                tbl_en  = 1'b1;
                state_d = UPD_WR;
            end
            UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_wdata = sat_update(tbl_rdata, upd_taken_q);
                state_d   = RUN;
            end
            default: state_d = INIT;
        endcase
    end

    // state, sweep index, latched update entry and response flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= INIT;
            idx_q           <= '0;
            upd_addr_q      <= '0;
            upd_taken_q     <= 1'b0;
            lk_resp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            upd_addr_q      <= upd_addr_d;
            upd_taken_q     <= upd_taken_d;
            lk_resp_valid_q <= lk_resp_valid_d;
        end
    end
endmodule

// File: tb/tb_bht_port_scheduler.sv
// tb_bht_port_scheduler: random and directed checks of the BHT port scheduler against a behavioural model
module tb_bht_port_scheduler;
    localparam int AW = 4;
    localparam int N  = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          lk_valid, lk_ready, lk_resp_valid, lk_taken;
    logic [AW-1:0] lk_addr, up_addr, tbl_addr;
    logic          up_valid, up_taken, up_ready;
    logic          tbl_en, tbl_we, init_done;
    logic [1:0]    tbl_wdata, tbl_rdata;
    logic [1:0]    mem [N];

    bht_port_scheduler #(.ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
        .lk_resp_valid(lk_resp_valid), .lk_taken(lk_taken),
        .up_valid(up_valid), .up_addr(up_addr), .up_taken(up_taken), .up_ready(up_ready),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // single-ported table macro with synchronous read
    always @(posedge clk) begin
        if (tbl_en && tbl_we) mem[tbl_addr] <= tbl_wdata;
        else if (tbl_en) tbl_rdata <= mem[tbl_addr];
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // behavioural model: sweep countdown, update phase, pending queue, architectural table
    int         init_left;
    int         phase;
    logic [AW-1:0] cur_addr;
    logic       cur_taken;
    logic [AW:0] q[$];
    logic [1:0] ref_tbl [N];
    bit         resp;
    logic       taken_exp;
    logic [AW+1:0] wlog[$];

    function automatic logic [1:0] sat(logic [1:0] c, logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        init_left = N;
        phase = 0;
        q.delete();
        resp = 1'b0;
    endtask

    task automatic model_advance();
        bit was_full;
        bit nxt_resp;
        was_full = (q.size() >= D);
        nxt_resp = 1'b0;
        if (init_left > 0) begin
            ref_tbl[N - init_left] = 2'b01;
            init_left--;
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2) begin
            ref_tbl[cur_addr] = sat(ref_tbl[cur_addr], cur_taken);
            phase = 0;
        end else if (lk_valid && !was_full) begin
            nxt_resp = 1'b1;
            taken_exp = ref_tbl[lk_addr][1];
        end else if (q.size() > 0) begin
            {cur_taken, cur_addr} = q.pop_front();
            phase = 1;
        end
        resp = nxt_resp;
        if (up_valid && !was_full) q.push_back({up_taken, up_addr});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_advance();
        #1;
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin : cmp
        logic e_en, e_we, e_lr;
        int   e_addr;
        logic [1:0] e_wd;
        if (chk_en) begin
            e_en = 1'b1; e_we = 1'b0; e_lr = 1'b0; e_addr = 0; e_wd = 2'b01;
            if (init_left > 0) begin
                e_we = 1'b1;
                e_addr = N - init_left;
            end else if (phase == 1) begin
                e_addr = int'(cur_addr);
            end else if (phase == 2) begin
                e_we = 1'b1;
                e_addr = int'(cur_addr);
                e_wd = sat(ref_tbl[cur_addr], cur_taken);
            end else begin
                e_lr = (q.size() < D);
                e_en = lk_valid && e_lr;
                e_addr = int'(lk_addr);
            end
            chk("up_ready", up_ready, q.size() < D);
            chk("init_done", init_done, init_left == 0);
            chk("lk_ready", lk_ready, e_lr);
            chk("tbl_en", tbl_en, e_en);
            if (e_en) begin
                chk("tbl_we", tbl_we, e_we);
                chk("tbl_addr", tbl_addr, e_addr);
                if (e_we) chk("tbl_wdata", tbl_wdata, e_wd);
            end
            chk("lk_resp_valid", lk_resp_valid, resp);
            chk("lk_taken", lk_taken, resp && taken_exp);
            if (init_left == 0 && tbl_en && tbl_we) wlog.push_back({tbl_addr, tbl_wdata});
        end
    end

    task automatic push(logic [AW-1:0] a, logic t);
        bit got;
        int n;
        up_valid = 1'b1; up_addr = a; up_taken = t;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            got = up_ready;
            step();
            n++;
        end
        if (!got) timeout("push");
        up_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || phase != 0 || init_left > 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) timeout("drain");
    endtask

    task automatic lookup(logic [AW-1:0] a);
        lk_valid = 1'b1; lk_addr = a;
        step();
        lk_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [AW+1:0] w9[$];
        rst = 1'b0; lk_valid = 1'b0; lk_addr = '0;
        up_valid = 1'b0; up_addr = '0; up_taken = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step(); step();
        chk("rst_lk_ready", lk_ready, 0);
        chk("rst_up_ready", up_ready, 1);
        chk("rst_tbl_we", tbl_we, 1);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_tbl_wdata", tbl_wdata, 2'b01);
        chk("rst_init_done", init_done, 0);
        rst = 1'b1;
        n = 0;
        while (!init_done && n < 40) begin step(); n++; end
        chk("init_cycles", n, 16);

        lookup(4'd7);
        chk("lk7_valid", lk_resp_valid, 1);
        chk("lk7_taken", lk_taken, 0);

        push(4'd3, 1'b1); push(4'd3, 1'b1); drain();
        chk("mem3_trained", mem[3], 2'b11);
        lookup(4'd3);
        chk("lk3_taken", lk_taken, 1);

        for (int i = 0; i < 5; i++) push(4'd5, 1'b0);
        drain();
        chk("mem5_floor", mem[5], 2'b00);
        for (int i = 0; i < 5; i++) push(4'd5, 1'b1);
        drain();
        chk("mem5_ceiling", mem[5], 2'b11);

        lk_valid = 1'b1; up_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lk_addr = 4'($urandom_range(15));
            up_addr = (i == 3) ? 4'd4 : 4'(i); up_taken = i[0];
            step();
        end
        up_valid = 1'b0;
        chk("starve_up_ready", up_ready, 0);
        chk("starve_lk_ready", lk_ready, 0);
        step(); chk("starve_rd_lk_ready", lk_ready, 0);
        step(); chk("starve_wr_lk_ready", lk_ready, 0);
        step(); chk("starve_back_lk_ready", lk_ready, 1);
        lk_valid = 1'b0;
        drain();
        chk("starve_idle", tbl_en, 0);

        wlog.delete();
        push(4'd9, 1'b1); push(4'd9, 1'b0); push(4'd9, 1'b1); drain();
        foreach (wlog[i]) if (wlog[i][AW+1:2] == 4'd9) w9.push_back(wlog[i]);
        chk("ord_count", w9.size(), 3);
        if (w9.size() == 3) begin
            chk("ord_w0", w9[0][1:0], 2'b10);
            chk("ord_w1", w9[1][1:0], 2'b01);
            chk("ord_w2", w9[2][1:0], 2'b10);
        end
        chk("mem9_final", mem[9], 2'b10);

        lk_valid = 1'b1; up_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_addr = 4'(10 + i); up_taken = 1'b1;
            step();
        end
        up_valid = 1'b0;
        step(); step();
        chk("midrst_in_wr", tbl_we, 1);
        rst = 1'b0; lk_valid = 1'b0;
        model_reset();
        #1;
        chk("midrst_addr", tbl_addr, 0);
        chk("midrst_up_ready", up_ready, 1);
        chk("midrst_resp", lk_resp_valid, 0);
        step();
        rst = 1'b1;
        wlog.delete();
        for (int i = 0; i < 16; i++) step();
        chk("midrst_init_done", init_done, 1);
        for (int i = 0; i < 5; i++) step();
        chk("midrst_no_write", wlog.size(), 0);
        chk("midrst_idle", tbl_en, 0);

        for (int i = 0; i < 2000; i++) begin
            lk_valid = ($urandom_range(1) == 1);
            lk_addr  = 4'($urandom_range(15));
            up_valid = ($urandom_range(4) < 2);
            up_addr  = 4'($urandom_range(15));
            up_taken = ($urandom_range(1) == 1);
            step();
        end
        lk_valid = 1'b0; up_valid = 1'b0;
        drain();
        for (int i = 0; i < N; i++) chk($sformatf("mem_final_%0d", i), mem[i], ref_tbl[i]);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bht_port_scheduler.md
# bht_port_scheduler

Scheduler that shares one single-ported 2-bit-counter branch history table (BHT) between the fetch-side prediction lookup stream and the execute-side branch-resolution update stream. It clears the table after reset, buffers resolved updates in a small FIFO, and performs each update as a read-modify-write with saturating arithmetic. It sits between the fetch/execute stages and the BHT memory macro, which has a synchronous read and one port.

## Interface
- ADDR_W, 4, BHT index width; the table has 2**ADDR_W entries.
- FIFO_DEPTH, 4, number of update FIFO entries; must be a power of two, at least 2.

- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset: asynchronous, active-low.
- lk_valid  in  1  lookup request.
- lk_addr  in  ADDR_W  lookup index.
- lk_ready  out  1  lookup accepted when lk_valid & lk_ready.
- lk_resp_valid  out  1  prediction valid (registered).
- lk_taken  out  1  predicted direction; equals tbl_rdata[1] while lk_resp_valid is high, else 0.
- up_valid  in  1  resolved-branch update.
- up_addr  in  ADDR_W  update index.
- up_taken  in  1  actual branch outcome.
- up_ready  out  1  equals !fifo_full.
- tbl_en  out  1  table port enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  ADDR_W  table index.
- tbl_wdata  out  2  counter written.
- tbl_rdata  in  2  counter read; valid the cycle after tbl_en & !tbl_we.
- init_done  out  1  high once the clear sweep is complete.

## Operation
- **INIT:** entered on reset. Writes WNT (2'b01) to index 0..2**ADDR_W-1, one index per cycle (tbl_en=1, tbl_we=1). After the last index: go to RUN and set init_done=1. lk_ready=0 in INIT. Updates are accepted into the FIFO if it is not full.
- **RUN:** the port serves a lookup or starts an update.
  - Lookup has priority: lk_ready=1 unless the FIFO is full.
  - When lk_valid & lk_ready: tbl_en=1, tbl_we=0, tbl_addr=lk_addr.
  - Otherwise, if the FIFO is non-empty: pop the head and go to UPD_RD.
  - FIFO full: lk_ready=0 and an update starts (starvation guard).
- **UPD_RD:** tbl_en=1, tbl_we=0, tbl_addr=head addr. Go to UPD_WR. lk_ready=0.
- **UPD_WR:** tbl_we=1, same address, tbl_wdata=sat(tbl_rdata, taken). Return to RUN. lk_ready=0.
- **sat arithmetic:** taken gives min(3, c+1); not taken gives max(0, c-1). The 2-bit counter never wraps.
- **Ordering:** updates are applied in FIFO order. A write in cycle N is visible to a read in cycle N+1. Lookups are not forwarded from queued updates, so a stale prediction is architecturally acceptable.
- **Simultaneous push and pop:** allowed; the occupancy count stays unchanged. A push while full is ignored, because up_ready is already low.
- **Reset mid-operation:** the FSM goes to INIT, the FIFO is emptied (pending updates are discarded), and lk_resp_valid=0.

## Timing
- **Reset values:**
  - lk_ready=0, lk_resp_valid=0, lk_taken=0, up_ready=1, init_done=0.
  - tbl_en=1, tbl_we=1, tbl_addr=0, tbl_wdata=2'b01 (first INIT write).
- **INIT duration:** exactly 2**ADDR_W cycles after reset release. init_done rises on the following edge.
- **Lookup latency:** accepted at edge N, lk_resp_valid is high for cycle N+1. The fetch side may issue back-to-back lookups, one per cycle.
- **Update cost:** 2 port cycles (UPD_RD, UPD_WR). An update entry leaves the FIFO at the edge entering UPD_RD.
- **up_ready:** combinational from FIFO occupancy; it does not see a pop in the same cycle.

## Structure
- **Package bht_pkg** holds:
  - the state enum: INIT, RUN, UPD_RD, UPD_WR;
  - the constant CNT_WNT=2'b01;
  - the 2-bit counter type;
  - the function sat_update(cnt, taken).
- **Sub-module bht_update_fifo:** parameterised by width (ADDR_W+1) and FIFO_DEPTH. It provides push/pop, full/empty, the head output, and asynchronous active-low clear.

## Test plan
- **Reset sweep:** ADDR_W=4. After reset release, 16 consecutive writes of 2'b01 to indices 0..15, then init_done=1. A lookup at index 7 returns lk_taken=0.
- **Train taken:** two updates (addr 3, taken) are drained. Table entry 3 reads 2'b11. A subsequent lookup at index 3 returns lk_taken=1 one cycle after acceptance.
- **Saturation:** five not-taken updates to index 5 leave the entry at 2'b00. Five taken updates then leave it at 2'b11, with no wrap at any point.
- **Priority and starvation:** hold lk_valid high continuously and push 4 updates. up_ready falls, lk_ready falls, and UPD_RD/UPD_WR runs. lk_ready returns after 2 cycles and the FIFO drains fully.
- **Same-address ordering:** queue taken, not-taken, taken to index 9, starting from 2'b01. The final entry is 2'b10 and the write sequence is 10, 01, 10.
- **Reset mid-update:** assert rst during UPD_WR with 3 entries queued. The FIFO empties, INIT restarts at index 0, and no update write appears after release.
